dvp_ddr3_frame_writer: RTL and testbench

Sequences one captured DVP frame into DDR3 through an Avalon-MM burst write master. It drains a show-ahead pixel FIFO filled by the DVP capture path and writes the frame to a byte-addressed buffer. The buffer base, the frame size and the capture enable come from the HPS-configured register block. It issues the one-cycle img_end pulse that clears capture_en[0] in that register block, so the HPS can process the frame and re-arm capture.

---
 rtl/dvp_ddr3_frame_writer_if.sv | 35 +++
 rtl/dvp_ddr3_frame_writer.sv | 154 +++++++++++++++
 tb/tb_dvp_ddr3_frame_writer.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dvp_ddr3_frame_writer_if.sv
// -----------------------------------------------------------------------------
// dvp_ddr3_frame_writer_if
// Avalon-MM burst write bus between the frame writer and the DDR3 port.
//   avm_address      burst start byte address       (master -> slave)
//   avm_burstcount   beats in the current burst     (master -> slave)
//   avm_write        write request                  (master -> slave)
//   avm_writedata    beat data                      (master -> slave)
//   avm_waitrequest  slave stall                    (slave  -> master)
// -----------------------------------------------------------------------------
interface dvp_ddr3_frame_writer_if #(
  parameter int DATA_W = 32,
  parameter int BCNT_W = 7
);
  logic [31:0]       avm_address;
  logic [BCNT_W-1:0] avm_burstcount;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic              avm_waitrequest;

  modport master (
    output avm_address,
    output avm_burstcount,
    output avm_write,
    output avm_writedata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_burstcount,
    input  avm_write,
    input  avm_writedata,
    output avm_waitrequest
  );
endinterface

// File: rtl/dvp_ddr3_frame_writer.sv
// -----------------------------------------------------------------------------
// dvp_ddr3_frame_writer
// Drains the show-ahead DVP pixel FIFO into a DDR3 frame buffer, one frame per
// arm, using Avalon-MM burst writes. Each burst is issued only once the FIFO
// already holds every beat of it, so the FIFO can never underflow.
//
// Ports
//   clk, rst      single clock domain, synchronous active-high reset
//   capture_en    arm bit; sampled only while idle
//   buffer_base   DDR3 byte address of the frame buffer (64-byte aligned)
//   img_size      frame size in bytes (whole FIFO words)
//   frame_start   one-cycle vsync pulse
//   fifo_usedw    words currently held in the pixel FIFO
//   fifo_q        FIFO head word (show-ahead)
//   fifo_rdreq    FIFO pop, asserted on every accepted beat
//   avm           Avalon-MM burst write master
//   img_end       one-cycle pulse after the last beat of the frame
//   busy          high from frame latch until img_end
// -----------------------------------------------------------------------------
module dvp_ddr3_frame_writer #(
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 16,
  parameter int BCNT_W    = 7,
  parameter int FIFO_UW   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture_en,
  input  logic [31:0]           buffer_base,
  input  logic [31:0]           img_size,
  input  logic                  frame_start,
  input  logic [FIFO_UW-1:0]    fifo_usedw,
  input  logic [DATA_W-1:0]     fifo_q,
  output logic                  fifo_rdreq,
  dvp_ddr3_frame_writer_if.master avm,
  output logic                  img_end,
  output logic                  busy
);

  localparam int          BYTES       = DATA_W / 8;
  localparam int          SHIFT       = $clog2(BYTES);
  localparam logic [31:0] BURST_LEN_W = 32'(BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_BURST,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [31:0]       r_base;
  logic [31:0]       r_words_left;
  logic [31:0]       r_address;
  logic [BCNT_W-1:0] r_burstcount;
  logic [BCNT_W-1:0] r_beat_cnt;
  logic              r_write;
  logic              r_img_end;
  logic              r_busy;

  logic [31:0]       w_frame_words;
  logic [31:0]       w_n_words;
  logic [31:0]       w_usedw;
  logic              w_fifo_ready;
  logic              w_accept;
  logic              w_last_beat;
  logic [31:0]       w_burst_bytes;
  logic [31:0]       w_words_after;

  assign w_frame_words = img_size >> SHIFT;

  // Next burst length: a full burst, or the remainder for the tail of the frame.
  assign w_n_words     = (r_words_left < BURST_LEN_W) ? r_words_left : BURST_LEN_W;
  assign w_usedw       = 32'(fifo_usedw);
  assign w_fifo_ready  = (w_usedw >= w_n_words);

  assign w_accept      = r_write & ~avm.avm_waitrequest;
  assign w_last_beat   = w_accept && (r_beat_cnt == (r_burstcount - BCNT_W'(1)));
  assign w_burst_bytes = 32'(r_burstcount) << SHIFT;
  assign w_words_after = r_words_left - 32'(r_burstcount);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_words_left <= '0;
      r_address    <= '0;
      r_burstcount <= '0;
      r_beat_cnt   <= '0;
      r_write      <= 1'b0;
      r_img_end    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_img_end <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Register inputs are only looked at here, so HPS writes during a
          // frame cannot disturb it.
          if (frame_start && capture_en && (w_frame_words != 32'd0)) begin
            r_base       <= buffer_base;
            r_words_left <= w_frame_words;
            r_busy       <= 1'b1;
            r_state      <= S_WAIT_DATA;
          end
        end

        S_WAIT_DATA: begin
          // Start a burst only when all of its beats are already buffered.
          if (w_fifo_ready) begin
            r_address    <= r_base;
            r_burstcount <= BCNT_W'(w_n_words);
            r_write      <= 1'b1;
            r_beat_cnt   <= '0;
            r_state      <= S_BURST;
          end
        end

        S_BURST: begin
          // Address, burstcount and write hold their values through stalls.
          if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + BCNT_W'(1);
            if (w_last_beat) begin
              r_write      <= 1'b0;
              r_base       <= r_base + w_burst_bytes;
              r_words_left <= w_words_after;
              if (w_words_after == 32'd0) begin
                r_img_end <= 1'b1;
                r_state   <= S_DONE;
              end else begin
                r_state   <= S_WAIT_DATA;
              end
            end
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign avm.avm_address    = r_address;
  assign avm.avm_burstcount = r_burstcount;
  assign avm.avm_write      = r_write;
  assign avm.avm_writedata  = fifo_q;
  assign fifo_rdreq         = w_accept;
  assign img_end            = r_img_end;
  assign busy               = r_busy;

endmodule

// File: tb/tb_dvp_ddr3_frame_writer.sv
// -----------------------------------------------------------------------------
// tb_dvp_ddr3_frame_writer
// Directed bench for the DVP-to-DDR3 frame writer. A small FIFO model holds
// words whose value equals their index in the frame; a negedge monitor tracks
// the Avalon traffic and the main process compares its tallies against
// hand-computed per-frame expectations from a vector table.
// -----------------------------------------------------------------------------
module tb_dvp_ddr3_frame_writer;

  localparam int DATA_W    = 32;
  localparam int BURST_LEN = 16;
  localparam int BCNT_W    = 7;
  localparam int FIFO_UW   = 10;

  logic                clk = 1'b0;
  logic                rst;
  logic                capture_en;
  logic [31:0]         buffer_base;
  logic [31:0]         img_size;
  logic                frame_start;
  logic [FIFO_UW-1:0]  fifo_usedw;
  logic [DATA_W-1:0]   fifo_q;
  logic                fifo_rdreq;
  logic                img_end;
  logic                busy;

  always #5 clk = ~clk;

  dvp_ddr3_frame_writer_if #(.DATA_W(DATA_W), .BCNT_W(BCNT_W)) bus ();

  dvp_ddr3_frame_writer #(
    .DATA_W   (DATA_W),
    .BURST_LEN(BURST_LEN),
    .BCNT_W   (BCNT_W),
    .FIFO_UW  (FIFO_UW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .capture_en (capture_en),
    .buffer_base(buffer_base),
    .img_size   (img_size),
    .frame_start(frame_start),
    .fifo_usedw (fifo_usedw),
    .fifo_q     (fifo_q),
    .fifo_rdreq (fifo_rdreq),
    .avm        (bus.master),
    .img_end    (img_end),
    .busy       (busy)
  );

  // ---------------- FIFO model: word k holds value k ----------------
  int   f_wr = 0;
  int   f_rd = 0;
  int   f_tick = 0;
  logic fifo_clr = 1'b1;
  int   fill_n = 0;
  logic trickle_en = 1'b0;
  int   trickle_max = 0;

  always @(posedge clk) begin
    if (fifo_clr) begin
      f_wr   <= fill_n;
      f_rd   <= 0;
      f_tick <= 0;
    end else begin
      if (fifo_rdreq) f_rd <= f_rd + 1;
      if (trickle_en && (f_wr < trickle_max)) begin
        if (f_tick == 3) begin
          f_wr   <= f_wr + 1;
          f_tick <= 0;
        end else begin
          f_tick <= f_tick + 1;
        end
      end
    end
  end

  assign fifo_usedw = FIFO_UW'(f_wr - f_rd);
  assign fifo_q     = DATA_W'(f_rd);

  // ---------------- slave stall generator ----------------
  logic stall_mode = 1'b0;
  always @(posedge clk) begin
    #1;
    bus.avm_waitrequest = stall_mode && ($urandom_range(0, 1) == 1);
  end

  // ---------------- monitor ----------------
  logic        mon_clr = 1'b1;
  logic [31:0] exp_base = '0;
  int          exp_words = 0;

  int m_beats, m_bursts, m_img_end, m_inburst;
  int m_data_err, m_addr_err, m_bcnt_err, m_stab_err, m_lat_err;
  int m_rdreq_err, m_end_err, m_uflow_err, m_idle_err, m_beat_err;
  logic [31:0] m_first_addr, m_last_addr;
  int          m_last_bcnt;
  logic        p_wait, p_ready, p_stall, p_write, p_last;
  logic [31:0] p_addr;
  logic [BCNT_W-1:0] p_bcnt;

  always @(negedge clk) begin : monitor
    logic acc;
    int   rem;
    int   n;
    if (mon_clr || rst) begin
      if (mon_clr) begin
        m_beats = 0; m_bursts = 0; m_img_end = 0; m_inburst = 0;
        m_data_err = 0; m_addr_err = 0; m_bcnt_err = 0; m_stab_err = 0;
        m_lat_err = 0; m_rdreq_err = 0; m_end_err = 0; m_uflow_err = 0;
        m_idle_err = 0; m_beat_err = 0;
        m_first_addr = '0; m_last_addr = '0; m_last_bcnt = 0;
      end
      p_wait = 1'b0; p_ready = 1'b0; p_stall = 1'b0; p_write = 1'b0; p_last = 1'b0;
      p_addr = '0; p_bcnt = '0;
    end else begin
      acc = bus.avm_write && !bus.avm_waitrequest;
      rem = exp_words - m_beats;
      n   = (rem < BURST_LEN) ? rem : BURST_LEN;
      if (fifo_rdreq != acc) m_rdreq_err++;
      if (!busy && bus.avm_write) m_idle_err++;
      if (p_wait && (bus.avm_write != p_ready)) m_lat_err++;
      if (p_stall && (!bus.avm_write || bus.avm_address != p_addr ||
                      bus.avm_burstcount != p_bcnt)) m_stab_err++;
      if (bus.avm_write && !p_write) begin
        if (m_bursts == 0) m_first_addr = bus.avm_address;
        m_bursts++;
        m_last_addr = bus.avm_address;
        m_last_bcnt = int'(bus.avm_burstcount);
        if (bus.avm_address != exp_base + 32'(m_beats * 4)) m_addr_err++;
        if (int'(bus.avm_burstcount) != n) m_bcnt_err++;
        if (int'(fifo_usedw) < int'(bus.avm_burstcount)) m_uflow_err++;
        m_inburst = 0;
      end
      if (img_end != p_last) m_end_err++;
      if (img_end) m_img_end++;
      p_last = acc && (m_beats + 1 == exp_words);
      if (acc) begin
        if (bus.avm_writedata != 32'(m_beats)) m_data_err++;
        m_beats++;
        m_inburst++;
        if (m_inburst > int'(bus.avm_burstcount)) m_beat_err++;
      end
      p_wait  = busy && !bus.avm_write && !img_end;
      p_ready = (int'(fifo_usedw) >= n);
      p_stall = bus.avm_write && bus.avm_waitrequest;
      p_addr  = bus.avm_address;
      p_bcnt  = bus.avm_burstcount;
      p_write = bus.avm_write;
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int fails  = 0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_proto(input string tag);
    chk({tag, ".data_err"},  m_data_err,  0);
    chk({tag, ".addr_err"},  m_addr_err,  0);
    chk({tag, ".bcnt_err"},  m_bcnt_err,  0);
    chk({tag, ".stall_err"}, m_stab_err,  0);
    chk({tag, ".lat_err"},   m_lat_err,   0);
    chk({tag, ".rdreq_err"}, m_rdreq_err, 0);
    chk({tag, ".end_err"},   m_end_err,   0);
    chk({tag, ".uflow_err"}, m_uflow_err, 0);
    chk({tag, ".idle_err"},  m_idle_err,  0);
    chk({tag, ".beat_err"},  m_beat_err,  0);
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int i;
    i = 0;
    while ((i < limit) && (busy || (i < 20))) begin
      tick();
      i++;
    end
    chk({tag, ".done_in_time"}, (i < limit) ? 1 : 0, 1);
  endtask

  typedef struct {
    logic [31:0] base;
    logic [31:0] size;
    bit          cap;
    bit          stall;
    bit          trickle;
    int          prefill;
    int          exp_beats;
    int          exp_bursts;
    int          exp_end;
    logic [31:0] exp_last_addr;
    int          exp_last_bcnt;
  } vec_t;

  task automatic arm_frame(input vec_t v);
    stall_mode  = v.stall;
    fill_n      = v.trickle ? 0 : v.prefill;
    trickle_max = v.prefill;
    trickle_en  = v.trickle;
    exp_base    = v.base;
    exp_words   = (v.cap && v.size != 0) ? int'(v.size >> 2) : 0;
    buffer_base = v.base;
    img_size    = v.size;
    capture_en  = v.cap;
    fifo_clr    = 1'b1;
    mon_clr     = 1'b1;
    tick();
    fifo_clr    = 1'b0;
    mon_clr     = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic check_frame(input vec_t v, input string tag);
    chk({tag, ".beats"},     m_beats,     v.exp_beats);
    chk({tag, ".bursts"},    m_bursts,    v.exp_bursts);
    chk({tag, ".img_end"},   m_img_end,   v.exp_end);
    chk({tag, ".last_addr"}, m_last_addr, v.exp_last_addr);
    chk({tag, ".last_bcnt"}, m_last_bcnt, v.exp_last_bcnt);
    chk({tag, ".busy"},      busy,        0);
    chk_proto(tag);
  endtask

  vec_t vecs[8];

  initial begin : global_guard
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected end of test");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t v;
    int   i;

    //         base          size  cap st tr pre beats bursts end last_addr     last_bcnt
    vecs[0] = '{32'h3000_0000, 256, 1, 0, 0, 64, 64, 4, 1, 32'h3000_00C0, 16};
    vecs[1] = '{32'h3000_0000, 100, 1, 0, 0, 25, 25, 2, 1, 32'h3000_0040, 9};
    vecs[2] = '{32'h3000_0000, 100, 1, 1, 0, 25, 25, 2, 1, 32'h3000_0040, 9};
    vecs[3] = '{32'h1000_0000, 100, 1, 0, 1, 25, 25, 2, 1, 32'h1000_0040, 9};
    vecs[4] = '{32'h3000_0000, 256, 0, 0, 0, 64, 0,  0, 0, 32'h0000_0000, 0};
    vecs[5] = '{32'h3000_0000, 0,   1, 0, 0, 64, 0,  0, 0, 32'h0000_0000, 0};
    vecs[6] = '{32'h2000_0040, 4,   1, 0, 0, 4,  1,  1, 1, 32'h2000_0040, 1};
    vecs[7] = '{32'h7FFF_FFC0, 64,  1, 1, 0, 16, 16, 1, 1, 32'h7FFF_FFC0, 16};

    rst         = 1'b1;
    capture_en  = 1'b0;
    buffer_base = '0;
    img_size    = '0;
    frame_start = 1'b0;
    tick(); tick(); tick();

    // Reset state
    chk("reset.avm_write",      bus.avm_write,      0);
    chk("reset.avm_address",    bus.avm_address,    0);
    chk("reset.avm_burstcount", bus.avm_burstcount, 0);
    chk("reset.img_end",        img_end,            0);
    chk("reset.busy",           busy,               0);
    rst      = 1'b0;
    fifo_clr = 1'b0;
    mon_clr  = 1'b0;
    tick();

    // Table-driven frames
    for (int k = 0; k < 8; k++) begin
      arm_frame(vecs[k]);
      wait_idle(3000, $sformatf("vec%0d", k));
      check_frame(vecs[k], $sformatf("vec%0d", k));
    end

    // frame_start while busy, register changes and capture_en drop mid-frame
    v = '{32'h5000_0000, 100, 1, 1, 0, 25, 25, 2, 1, 32'h5000_0040, 9};
    arm_frame(v);
    tick(); tick(); tick();
    buffer_base = 32'h6000_0000;
    img_size    = 256;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    capture_en  = 1'b0;
    wait_idle(3000, "midframe");
    check_frame(v, "midframe");
    chk("midframe.first_addr", m_first_addr, 32'h5000_0000);

    // Reset in the middle of a burst
    v = '{32'h3000_0000, 256, 1, 1, 0, 64, 0, 0, 0, 32'h0, 0};
    arm_frame(v);
    i = 0;
    while ((i < 500) && (m_beats < 5)) begin
      tick();
      i++;
    end
    chk("rstmid.reached_burst", (i < 500) ? 1 : 0, 1);
    chk("rstmid.write_before", bus.avm_write, 1);
    rst = 1'b1;
    tick();
    chk("rstmid.avm_write",      bus.avm_write,      0);
    chk("rstmid.busy",           busy,               0);
    chk("rstmid.img_end",        img_end,            0);
    chk("rstmid.avm_address",    bus.avm_address,    0);
    chk("rstmid.avm_burstcount", bus.avm_burstcount, 0);
    rst     = 1'b0;
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    chk("rstmid.quiet_img_end", m_img_end,     0);
    chk("rstmid.quiet_beats",   m_beats,       0);
    chk("rstmid.quiet_write",   bus.avm_write, 0);
    chk("rstmid.quiet_busy",    busy,          0);

    // Fresh frame after the reset starts at the new base
    v = '{32'h4000_0000, 128, 1, 0, 0, 32, 32, 2, 1, 32'h4000_0040, 16};
    arm_frame(v);
    wait_idle(3000, "restart");
    check_frame(v, "restart");
    chk("restart.first_addr", m_first_addr, 32'h4000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
